// File: rtl/cac_fns_dec_seq.sv
// Iterative Fibonacci-numeral-system CAC decoder: one codeword bit per cycle, LSB first.
module cac_fns_dec_seq #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        sh_q, sh_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0]   wb_q, wb_d;
  logic                sat_a_q, sat_a_d;
  logic                sat_b_q, sat_b_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_W:0]     acc_sum;
  logic [DATA_W:0]     w_sum;
  logic                load;

  // Carry-extended adders for the accumulator and the Fibonacci weight recurrence
  assign acc_sum = {1'b0, acc_q} + {1'b0, wa_q};
  assign w_sum   = {1'b0, wa_q} + {1'b0, wb_q};

  // Handshake and status decode from the state register
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign load      = in_valid & in_ready;
  assign dataout   = acc_q;
  assign ovf       = ovf_q;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      sat_a_q <= 1'b0;
      sat_b_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      sat_a_q <= sat_a_d;
      sat_b_q <= sat_b_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates; an accepted word always restarts from F1/F2
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    sat_a_d = sat_a_q;
    sat_b_d = sat_b_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_RUN: begin
        if (sh_q[0]) begin
          acc_d = acc_sum[DATA_W-1:0];
          // A saturated weight means its true value alone already exceeds the range
          ovf_d = ovf_q | acc_sum[DATA_W] | sat_a_q;
        end
        sh_d    = sh_q >> 1;
        wa_d    = wb_q;
        sat_a_d = sat_b_q;
        wb_d    = w_sum[DATA_W-1:0];
        sat_b_d = sat_a_q | sat_b_q | w_sum[DATA_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready && !in_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    if (load) begin
      state_d = ST_RUN;
      sh_d    = codein;
      acc_d   = '0;
      wa_d    = DATA_W'(1);
      wb_d    = DATA_W'(1);
      sat_a_d = 1'b0;
      sat_b_d = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_cac_fns_dec_seq.sv
// Directed bench for the FNS CAC decoder at three parameter points.
module tb_cac_fns_dec_seq;

  localparam int unsigned N  = 8;
  localparam int unsigned N12 = 12;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  codein;
  logic        in_ready, out_valid, ovf, busy;
  logic [5:0]  dataout;
  logic        in_ready5, out_valid5, ovf5, busy5;
  logic [4:0]  dataout5;

  logic        iv12, or12;
  logic [11:0] code12;
  logic        ir12, ov12, ovf12, busy12;
  logic [8:0]  d12;

  int errors = 0;
  int checks = 0;

  cac_fns_dec_seq #(.N(8), .DATA_W(6), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codein(codein), .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .ovf(ovf), .busy(busy)
  );

  cac_fns_dec_seq #(.N(8), .DATA_W(5), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .codein(codein), .out_valid(out_valid5), .out_ready(out_ready),
    .dataout(dataout5), .ovf(ovf5), .busy(busy5)
  );

  cac_fns_dec_seq #(.N(12), .DATA_W(9), .CNT_W(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12),
    .codein(code12), .out_valid(ov12), .out_ready(or12),
    .dataout(d12), .ovf(ovf12), .busy(busy12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference value of a codeword: bit i weighted by F(i+1)
  function automatic int fns_val(input logic [11:0] c, input int n);
    int a = 1, b = 1, s = 0, t;
    for (int i = 0; i < n; i++) begin
      if (c[i]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  // One word through the 8-bit decoders with out_ready high; codein is scrambled during RUN
  task automatic run_word(input logic [7:0] code, input int exp, input string name);
    in_valid = 1'b1;
    codein   = code;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    codein   = ~code;
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_run_in_ready"}, 32'(in_ready), 32'd0);
    repeat (N - 1) tick();
    check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(dataout), 32'(exp % 64));
    check({name, "_ovf"}, 32'(ovf), 32'(exp > 63));
    check({name, "_valid5"}, 32'(out_valid5), 32'd1);
    check({name, "_data5"}, 32'(dataout5), 32'(exp % 32));
    check({name, "_ovf5"}, 32'(ovf5), 32'(exp > 31));
    tick();
    check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int q_exp[$];
    int got;
    int cyc;
    int e;
    logic pend;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; codein = '0;
    iv12 = 1'b0; or12 = 1'b1; code12 = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic decodes
    run_word(8'hFF, 54, "ff");
    run_word(8'h00, 0,  "zero");
    run_word(8'h80, 21, "msb");
    run_word(8'h05, 3,  "w05");
    run_word(8'h03, 2,  "w03");
    run_word(8'h01, 1,  "w01");

    // Backpressure then same-edge handoff
    out_ready = 1'b0;
    in_valid  = 1'b1; codein = 8'hFF;
    tick();
    in_valid = 1'b0; codein = 8'h00;
    repeat (N) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; codein = 8'h55;
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(dataout), 32'd54);
      check("bp_hold_ovf", 32'(ovf), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; codein = 8'h0A;
    #1;
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; codein = 8'hFF;
    check("handoff_valid_drop", 32'(out_valid), 32'd0);
    check("handoff_busy", 32'(busy), 32'd1);
    repeat (N - 1) tick();
    check("handoff_early", 32'(out_valid), 32'd0);
    tick();
    check("handoff_valid", 32'(out_valid), 32'd1);
    check("handoff_data", 32'(dataout), 32'd4);
    check("handoff_ovf", 32'(ovf), 32'd0);
    tick();

    // Reset in the middle of RUN
    in_valid = 1'b1; codein = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("prerst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(dataout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("postrst_no_valid", 32'(out_valid), 32'd0);
    run_word(8'h80, 21, "postrst");

    // 12-bit instance: full-ones latency and value
    iv12 = 1'b1; code12 = 12'hFFF;
    tick();
    iv12 = 1'b0; code12 = 12'h000;
    repeat (N12 - 1) tick();
    check("n12_early", 32'(ov12), 32'd0);
    tick();
    check("n12_valid", 32'(ov12), 32'd1);
    check("n12_data", 32'(d12), 32'd376);
    check("n12_ovf", 32'(ovf12), 32'd0);
    tick();

    // 12-bit instance: random words with random handshakes against the reference
    got = 0; cyc = 0; pend = 1'b0;
    while (got < 300 && cyc < 20000) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        code12 = 12'($urandom);
        pend = 1'b1;
      end
      iv12 = pend;
      or12 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov12 && or12) begin
        if (q_exp.size() == 0) begin
          check("rnd_spurious_valid", 32'(ov12), 32'd0);
        end else begin
          e = q_exp.pop_front();
          check("rnd_data", 32'(d12), 32'(e % 512));
          check("rnd_ovf", 32'(ovf12), 32'(e > 511));
        end
        got++;
      end
      if (iv12 && ir12) begin
        q_exp.push_back(fns_val(code12, N12));
        pend = 1'b0;
      end
      tick();
      cyc++;
    end
    check("rnd_completed", 32'(got), 32'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
